// File: rtl/fft8_stream_r2.sv
// fft8_stream_r2: serial-in, natural-order-out 8-point radix-2 DIT FFT.
// One time-shared butterfly; fixed-point twiddles with round-half-up.
module fft8_stream_r2 #(
  parameter int DW  = 16,
  parameter int OW  = DW + 3,
  parameter int TW  = 14,
  parameter int TWC = 11585
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_re,
  output logic [OW-1:0] out_im,
  output logic [2:0]    out_idx,
  output logic          busy
);
  localparam int PW = OW + TW + 2;
  localparam logic signed [PW-1:0] TWP  = PW'(TWC);
  localparam logic signed [PW-1:0] HALF = PW'(1) << (TW - 1);

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] bf_q, bf_d;

  logic signed [OW-1:0] mem_re [8];
  logic signed [OW-1:0] mem_im [8];

  logic                 in_hs;
  logic [1:0]           stg, m, tw;
  logic [2:0]           ia, ib;
  logic signed [OW-1:0] a_re, a_im, b_re, b_im;
  logic signed [OW-1:0] p_re, p_im;
  logic signed [PW-1:0] sum_x, dif_x;
  logic [OW-1:0]        ext;

  function automatic logic signed [OW-1:0] rnd(
    input logic signed [PW-1:0] x
  );
    logic signed [PW-1:0] t;
    t = (x + HALF) >>> TW;
    return t[OW-1:0];
  endfunction

  assign in_hs = in_ready & in_valid;
  assign ext   = {{(OW-DW){in_data[DW-1]}}, in_data};

  // Butterfly addressing: span = 2^stg, j = i mod span
  always_comb begin
    stg = bf_q[3:2];
    m   = bf_q[1:0];
    ia  = 3'd0;
    ib  = 3'd0;
    tw  = 2'd0;
    unique case (stg)
      2'd0: begin
        ia = {m, 1'b0};
        ib = {m, 1'b1};
      end
      2'd1: begin
        ia = {m[1], 1'b0, m[0]};
        ib = {m[1], 1'b1, m[0]};
        tw = {m[0], 1'b0};
      end
      default: begin
        ia = {1'b0, m};
        ib = {1'b1, m};
        tw = m;
      end
    endcase
  end

  always_comb begin
    a_re  = mem_re[ia];
    a_im  = mem_im[ia];
    b_re  = mem_re[ib];
    b_im  = mem_im[ib];
    sum_x = PW'(b_re) + PW'(b_im);
    dif_x = PW'(b_im) - PW'(b_re);
    p_re  = b_re;
    p_im  = b_im;
    unique case (tw)
      2'd1: begin
        p_re = rnd(sum_x * TWP);
        p_im = rnd(dif_x * TWP);
      end
      2'd2: begin
        p_re = b_im;
        p_im = -b_re;
      end
      2'd3: begin
        p_re = rnd(dif_x * TWP);
        p_im = rnd((-sum_x) * TWP);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bf_d      = bf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    out_idx   = 3'd0;
    out_re    = '0;
    out_im    = '0;
    unique case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        bf_d = bf_q + 4'd1;
        if (bf_q == 4'd11) begin
          bf_d    = 4'd0;
          state_d = UNLOAD;
        end
      end
      UNLOAD: begin
        out_valid = 1'b1;
        out_idx   = cnt_q;
        out_re    = mem_re[cnt_q];
        out_im    = mem_im[cnt_q];
        if (out_ready) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= 3'd0;
      bf_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bf_q    <= bf_d;
    end
  end

  // Samples land bit-reversed so the in-place result is in natural order
  always_ff @(posedge clk) begin
    if (in_hs) begin
      mem_re[{cnt_q[0], cnt_q[1], cnt_q[2]}] <= ext;
      mem_im[{cnt_q[0], cnt_q[1], cnt_q[2]}] <= '0;
    end else if (state_q == COMPUTE) begin
      mem_re[ia] <= a_re + p_re;
      mem_im[ia] <= a_im + p_im;
      mem_re[ib] <= a_re - p_re;
      mem_im[ib] <= a_im - p_im;
    end
  end

endmodule

// File: doc/fft8_stream_r2.md
Name: fft8_stream_r2

Overview:
Sequential, parametrised 8-point radix-2 decimation-in-time FFT, successor to the team's hand-expanded combinational 8-point FFT.
- Accepts 8 signed real samples serially over a valid/ready handshake.
- Computes in place with one time-shared butterfly: 3 stages × 4 butterflies.
- Streams out 8 complex bins in natural order over a second valid/ready handshake.
- Uses fixed-point twiddles with defined round-half-up, replacing floating-point constants and their rounding error.
- Sits between the sample front end and the spectral post-processing path.

Parameters:
- DW, 16: input sample width (signed, two's complement).
- OW, DW+3: output/internal storage width, sized for 8x growth.
- TW, 14: twiddle fraction bits.
- TWC, 11585: twiddle magnitude constant, round(2^TW/sqrt(2)); must match TW.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample present.
- in_ready  out  1  block accepts a sample this cycle.
- in_data  in  DW  signed real sample f_n, n = arrival order 0..7.
- out_valid  out  1  bin present.
- out_ready  in  1  downstream accepts the bin.
- out_re  out  OW  signed real part of F_k.
- out_im  out  OW  signed imaginary part of F_k.
- out_idx  out  3  bin index k of the current output.
- busy  out  1  high in COMPUTE or UNLOAD.

Behaviour:
- Reset (asynchronous, rst_n=0): state=LOAD; load and output counters=0; in_ready=1, out_valid=0, out_re=0, out_im=0, out_idx=0, busy=0. The memory (8 × {re, im}, OW bits each) is not cleared.
- Reset asserted mid-operation aborts the frame. No partial output is emitted after release.
- State machine: LOAD -> COMPUTE -> UNLOAD -> LOAD.
- LOAD:
  - in_ready=1.
  - Handshake (in_valid&in_ready) writes sign-extended in_data to address bitrev3(n), with im=0, then increments n.
  - On the 8th handshake, go to COMPUTE.
- COMPUTE:
  - in_ready=0, busy=1.
  - Runs exactly 12 cycles: stage s=0,1,2; span=2^s; 4 butterflies per stage; one butterfly per cycle.
  - Butterfly pair (a at i, b at i+span) uses twiddle W8^(j·4/span), where j = i mod span.
  - Writes back a' = a + b·W and b' = a − b·W in the same cycle.
- Twiddle multiply:
  - W^0: exact pass-through.
  - W^2 (= −j): exact, (re, im) -> (im, −re).
  - W^1: p_re = R((b_re + b_im)·TWC), p_im = R((b_im − b_re)·TWC).
  - W^3: p_re = R((b_im − b_re)·TWC), p_im = R(−(b_re + b_im)·TWC).
  - R(x) = (x + 2^(TW−1)) >>> TW, i.e. round-half-toward-+inf with an arithmetic shift. Each product is rounded exactly once.
  - Products are computed at full width (OW+TW+2); the result is truncated to OW. OW=DW+3 guarantees no overflow for any real input frame.
- UNLOAD:
  - Entered the cycle after the 12th butterfly. First out_valid rises 13 cycles after the 8th input handshake.
  - out_valid=1 with out_idx=k, k=0..7 in order; out_re/out_im = memory[k].
  - Outputs stay stable while out_valid&!out_ready (backpressure of any length).
  - The handshake advances k. After the k=7 handshake, out_valid=0 next cycle and state=LOAD.
- in_ready is 0 during COMPUTE and UNLOAD. Inputs offered then are not consumed.
- No overlap of frames: the next frame's first sample is accepted no earlier than the cycle after the k=7 handshake.
- Throughput (no backpressure): 8 + 12 + 8 = 28 cycles per frame.

Test Plan:
- Impulse: f=[1000,0,0,0,0,0,0,0] -> every bin re=1000, im=0; out_idx 0..7 in order; first out_valid exactly 13 cycles after the last input handshake.
- DC: all f=100 -> F0=(800,0), F1..F7=(0,0).
- Shifted impulse: f1=1000, others 0 -> F0=(1000,0), F1=(707,−707), F2=(0,−1000), F3=(−707,−707), F4=(−1000,0), F5=(−707,707), F6=(0,1000), F7=(707,707). Checks twiddle rounding.
- Alternating f=[100,−100,…] -> F4=(800,0), all other bins (0,0). Full scale: all f=−2^(DW−1) -> F0 re=−8·2^(DW−1), no wrap.
- Backpressure: out_ready low for 5 cycles at k=3 -> out_re/out_im/out_idx held constant, no bin lost or duplicated. in_valid held high during COMPUTE/UNLOAD -> no extra samples consumed.
- Reset mid-COMPUTE: rst_n pulsed low in butterfly cycle 6 -> outputs zero immediately; no out_valid; a new frame loaded afterwards produces correct results.
